// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel enable, coordinates, delayed syncs,
// frame tick and animation frame counter.
`ifndef WIDTH_LOG2
`define WIDTH_LOG2 10
`endif
`ifndef HEIGHT_LOG2
`define HEIGHT_LOG2 10
`endif
`ifndef MAX_ANIMATION_FRAME_LOG2
`define MAX_ANIMATION_FRAME_LOG2 4
`endif

module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2,
    parameter int ANIM_DIV   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    output logic                                 pixel_en,
    output logic [`WIDTH_LOG2-1:0]               x,
    output logic [`HEIGHT_LOG2-1:0]              y,
    output logic                                 toDisplay,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 frame_tick,
    output logic [`MAX_ANIMATION_FRAME_LOG2-1:0] animation_timer
);
    localparam int XW      = `WIDTH_LOG2;
    localparam int YW      = `HEIGHT_LOG2;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int FW      = $clog2(ANIM_DIV + 1);
    localparam int PW      = SYNC_DELAY + 1;
    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] F_LAST = FW'(ANIM_DIV - 1);

    if (H_TOTAL > 2 ** XW || V_TOTAL > 2 ** YW) begin : g_width_check
        $error("coordinate width too small for raster totals");
    end

    logic [DW-1:0] div_cnt;
    logic [FW-1:0] frame_div;
    logic [PW-1:0] hs_pipe, vs_pipe;
    logic [XW-1:0] h_inc, h_cur;
    logic [YW-1:0] v_inc, v_cur;
    logic          last_div, hs_raw, vs_raw;

    always_comb begin
        last_div = div_cnt == D_LAST;
        h_inc    = x == H_LAST ? '0 : x + 1'b1;
        v_inc    = x != H_LAST ? y : (y == V_LAST ? '0 : y + 1'b1);
        hs_raw   = !(32'(h_inc) >= H_VISIBLE + H_FRONT && 32'(h_inc) < H_VISIBLE + H_FRONT + H_SYNC);
        vs_raw   = !(32'(v_inc) >= V_VISIBLE + V_FRONT && 32'(v_inc) < V_VISIBLE + V_FRONT + V_SYNC);
        // counters as they will stand during the cycle the next pixel_en is high
        h_cur    = pixel_en ? h_inc : x;
        v_cur    = pixel_en ? v_inc : y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt         <= '0;
            pixel_en        <= 1'b0;
            x               <= '0;
            y               <= '0;
            toDisplay       <= 1'b0;
            hs_pipe         <= '1;
            vs_pipe         <= '1;
            frame_tick      <= 1'b0;
            frame_div       <= '0;
            animation_timer <= '0;
        end else begin
            div_cnt    <= last_div ? '0 : div_cnt + 1'b1;
            pixel_en   <= last_div;
            frame_tick <= last_div && h_cur == H_LAST && v_cur == V_LAST;
            if (pixel_en) begin
                x         <= h_inc;
                y         <= v_inc;
                toDisplay <= 32'(h_inc) < H_VISIBLE && 32'(v_inc) < V_VISIBLE;
                hs_pipe   <= (hs_pipe << 1) | PW'(hs_raw);
                vs_pipe   <= (vs_pipe << 1) | PW'(vs_raw);
            end
            if (frame_tick) begin
                frame_div <= frame_div == F_LAST ? '0 : frame_div + 1'b1;
                if (frame_div == F_LAST) animation_timer <= animation_timer + 1'b1;
            end
        end
    end

    assign hsync = hs_pipe[SYNC_DELAY];
    assign vsync = vs_pipe[SYNC_DELAY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen on a shrunken raster against an
// arithmetic model indexed by clocks since reset release, with random resets.
`ifndef WIDTH_LOG2
`define WIDTH_LOG2 10
`endif
`ifndef HEIGHT_LOG2
`define HEIGHT_LOG2 10
`endif
`ifndef MAX_ANIMATION_FRAME_LOG2
`define MAX_ANIMATION_FRAME_LOG2 4
`endif

module tb_vga_timing_gen;
    localparam int D = 2, HV = 8, HF = 2, HS = 3, HB = 2, VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int SD = 2, AD = 2;
    localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB, FR = HT * VT;
    localparam int AW = `MAX_ANIMATION_FRAME_LOG2;

    logic clk = 0, rst_n = 0;
    logic pixel_en, toDisplay, hsync, vsync, frame_tick;
    logic [`WIDTH_LOG2-1:0] x;
    logic [`HEIGHT_LOG2-1:0] y;
    logic [AW-1:0] animation_timer;
    int n, checks = 0, failures = 0;

    vga_timing_gen #(.CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_DELAY(SD), .ANIM_DIV(AD)
    ) dut (.clk(clk), .rst_n(rst_n), .pixel_en(pixel_en), .x(x), .y(y), .toDisplay(toDisplay),
        .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick), .animation_timer(animation_timer));

    always #5 clk = ~clk;
    always @(posedge clk or negedge rst_n) n <= !rst_n ? 0 : n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d actual=%0d required=%0d", nm, n, act, exp);
        end
    endtask

    // pixels whose x/y have been loaded after n clocks since release
    function automatic int kp(input int t);
        return t >= 1 ? (t - 1) / D : 0;
    endfunction
    function automatic logic hraw(input int j);
        return j < 0 || !((j % HT) >= HV + HF && (j % HT) < HV + HF + HS);
    endfunction
    function automatic logic vraw(input int j);
        return j < 0 || !(((j / HT) % VT) >= VV + VF && ((j / HT) % VT) < VV + VF + VS);
    endfunction

    always @(negedge clk) if (rst_n) begin
        int k;
        k = kp(n);
        chk("pixel_en", 32'(pixel_en), 32'(n >= 1 && n % D == 0));
        chk("x", 32'(x), k % HT);
        chk("y", 32'(y), (k / HT) % VT);
        chk("toDisplay", 32'(toDisplay), 32'(k > 0 && k % HT < HV && (k / HT) % VT < VV));
        chk("hsync", 32'(hsync), 32'(hraw(k - SD)));
        chk("vsync", 32'(vsync), 32'(vraw(k - SD)));
        chk("frame_tick", 32'(frame_tick), 32'(n >= 1 && n % D == 0 && k % FR == FR - 1));
        chk("animation_timer", 32'(animation_timer), ((k / FR) / AD) % (1 << AW));
    end

    task automatic wait_n(input int t);
        while (n < t) @(negedge clk);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_x"}, 32'(x), 0);
        chk({nm, "_y"}, 32'(y), 0);
        chk({nm, "_td"}, 32'(toDisplay), 0);
        chk({nm, "_pe"}, 32'(pixel_en), 0);
        chk({nm, "_ft"}, 32'(frame_tick), 0);
        chk({nm, "_hs"}, 32'(hsync), 1);
        chk({nm, "_vs"}, 32'(vsync), 1);
        chk({nm, "_anim"}, 32'(animation_timer), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst_n = 1;
        wait_n(2);   chk("lit_pe_first", 32'(pixel_en), 1); chk("lit_x0", 32'(x), 0);
        wait_n(3);   chk("lit_pe_low", 32'(pixel_en), 0);   chk("lit_x1", 32'(x), 1);
        wait_n(23);  chk("lit_hs_before", 32'(hsync), 1);
        wait_n(25);  chk("lit_hs_low", 32'(hsync), 0);
        wait_n(31);  chk("lit_wrap_x", 32'(x), 0);          chk("lit_wrap_y", 32'(y), 1);
        wait_n(213); chk("lit_vs_before", 32'(vsync), 1);
        wait_n(215); chk("lit_vs_low", 32'(vsync), 0);
        wait_n(330); chk("lit_tick", 32'(frame_tick), 1);
        wait_n(331); chk("lit_tick_end", 32'(frame_tick), 0); chk("lit_frame_y", 32'(y), 0);
        wait_n(660); chk("lit_anim0", 32'(animation_timer), 0);
        wait_n(661); chk("lit_anim1", 32'(animation_timer), 1);
        wait_n(40 * FR * D);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(700, 50)) @(negedge clk);
            #3 rst_n = 0;
            #1 chk_reset("rst_mid");
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst_n = 1;
        end
        wait_n(3 * FR * D);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
